// File: rtl/param_pipe_adder_pkg.sv
// Shared helpers for the segmented pipelined adder:
// segment sizing, configuration sanity and saturation limits.
package param_pipe_adder_pkg;

    localparam int MAXW = 1024;

    function automatic int seg_w(input int w, input int s);
        return (s >= 1) ? w / s : w;
    endfunction

    function automatic bit cfg_ok(input int w, input int s);
        return (s >= 1) && (w >= s) && (w <= MAXW) && ((w % s) == 0);
    endfunction

    // neg=1 gives signed min {1,0..0}; neg=0 gives signed max {0,1..1}
    function automatic logic [MAXW-1:0] sat_lim(input int w, input bit neg);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (i < w - 1)
                r[i] = ~neg;
            else if (i == w - 1)
                r[i] = neg;
        end
        return r;
    endfunction

endpackage

// File: rtl/param_pipe_adder_seg.sv
// One carry-chain segment: plain W-bit full adder.
module adder_seg #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co
);

    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};

endmodule

// File: rtl/param_pipe_adder.sv
// Add/subtract unit with the carry chain cut into STAGES registered
// segments; operands are skewed in, results deskewed out.
module param_pipe_adder
    import param_pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = seg_w(WIDTH, STAGES);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_lim(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_lim(WIDTH, 1'b1));

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("param_pipe_adder: bad WIDTH/STAGES");
    end

    logic [WIDTH-1:0]  w_bp;
    logic              w_c0;
    logic [STAGES-1:0] w_cq;
    logic [WIDTH-1:0]  w_raw;
    logic              w_ovf;
    logic              r_sa;
    logic              r_sb;
    logic [STAGES-1:0] r_v;
    logic              r_ov;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    assign w_bp = sub ? ~b : b;
    assign w_c0 = sub ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0] w_a;
        logic [SEG-1:0] w_b;
        logic [SEG-1:0] w_s;
        logic           w_ci;
        logic           w_co;
        logic           r_co;
        logic [SEG-1:0] r_ds [STAGES-k];

        if (k == 0) begin : g_in
            assign w_a  = a[SEG-1:0];
            assign w_b  = w_bp[SEG-1:0];
            assign w_ci = w_c0;
        end else begin : g_skew
            logic [SEG-1:0] r_ska [k];
            logic [SEG-1:0] r_skb [k];

            always_ff @(posedge clk) begin
                if (ce) begin
                    r_ska[0] <= a[k*SEG +: SEG];
                    r_skb[0] <= w_bp[k*SEG +: SEG];
                    for (int j = 1; j < k; j++) begin
                        r_ska[j] <= r_ska[j-1];
                        r_skb[j] <= r_skb[j-1];
                    end
                end
            end

            assign w_a  = r_ska[k-1];
            assign w_b  = r_skb[k-1];
            assign w_ci = w_cq[k-1];
        end

        adder_seg #(.W(SEG)) u_seg (
            .i_a  (w_a),
            .i_b  (w_b),
            .i_ci (w_ci),
            .o_s  (w_s),
            .o_co (w_co)
        );

        always_ff @(posedge clk) begin
            if (ce) begin
                r_co    <= w_co;
                r_ds[0] <= w_s;
                for (int j = 1; j < STAGES - k; j++)
                    r_ds[j] <= r_ds[j-1];
            end
        end

        assign w_cq[k]             = r_co;
        assign w_raw[k*SEG +: SEG] = r_ds[STAGES-1-k];

        // Sign bits ride with the top segment so ovf lines up with w_raw
        if (k == STAGES - 1) begin : g_sign
            always_ff @(posedge clk) begin
                if (ce) begin
                    r_sa <= w_a[SEG-1];
                    r_sb <= w_b[SEG-1];
                end
            end
        end
    end

    assign w_ovf = (r_sa == r_sb) && (w_raw[MSB] != r_sa);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_ov   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (ce) begin
            r_v[0] <= in_valid;
            for (int j = 1; j < STAGES; j++)
                r_v[j] <= r_v[j-1];
            r_ov <= r_v[STAGES-1];
            if (r_v[STAGES-1]) begin
                if (SAT && w_ovf)
                    r_sum <= r_sa ? SMIN : SMAX;
                else
                    r_sum <= w_raw;
                r_cout <= w_cq[STAGES-1];
                r_ovf  <= w_ovf;
            end else begin
                r_sum  <= '0;
                r_cout <= 1'b0;
                r_ovf  <= 1'b0;
            end
        end
    end

    assign out_valid = r_ov;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_param_pipe_adder.sv
// Directed and random checks of param_pipe_adder (WIDTH=8, STAGES=2),
// one wrapping and one saturating instance on shared inputs.
module tb_param_pipe_adder;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce = 1'b1;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         ov0, co0, of0;
    logic [W-1:0] sum0;
    logic         ov1, co1, of1;
    logic [W-1:0] sum1;
    logic [10:0]  o0, o1;

    int checks = 0;
    int errors = 0;
    int nv;

    logic [10:0] m0 [S+1];
    logic [10:0] m1 [S+1];

    always #5 clk = ~clk;

    param_pipe_adder #(.WIDTH(W), .STAGES(S), .SAT(1'b0)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
        .sub(sub), .a(a), .b(b), .cin(cin),
        .out_valid(ov0), .sum(sum0), .cout(co0), .ovf(of0)
    );

    param_pipe_adder #(.WIDTH(W), .STAGES(S), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
        .sub(sub), .a(a), .b(b), .cin(cin),
        .out_valid(ov1), .sum(sum1), .cout(co1), .ovf(of1)
    );

    assign o0 = {ov0, sum0, co0, of0};
    assign o1 = {ov1, sum1, co1, of1};

    // Signed/unsigned integer arithmetic, independent of the bit recipe
    function automatic logic [10:0] ref_out(
        input logic [7:0] ra, input logic [7:0] rb,
        input logic rc, input logic rs, input logic rsat);
        int sa, sb, ua, ub, ci, r, ur;
        logic co, ov;
        logic [7:0] s;
        sa = $signed(ra);
        sb = $signed(rb);
        ua = ra;
        ub = rb;
        ci = rc;
        if (rs) begin
            r  = sa - sb - ci;
            ur = ua - ub - ci;
            co = (ur >= 0);
        end else begin
            r  = sa + sb + ci;
            ur = ua + ub + ci;
            co = (ur > 255);
        end
        ov = (r > 127) || (r < -128);
        s  = r[7:0];
        if (rsat && ov)
            s = (r > 127) ? 8'h7F : 8'h80;
        return {1'b1, s, co, ov};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs,
                       input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r_, input logic c_, input logic v_,
                       input logic s_, input logic [7:0] a_,
                       input logic [7:0] b_, input logic ci_);
        rst = r_; ce = c_; in_valid = v_; sub = s_;
        a = a_; b = b_; cin = ci_;
        @(posedge clk);
        if (r_) begin
            for (int i = 0; i <= S; i++) begin
                m0[i] = '0;
                m1[i] = '0;
            end
        end else if (c_) begin
            for (int i = S; i > 0; i--) begin
                m0[i] = m0[i-1];
                m1[i] = m1[i-1];
            end
            m0[0] = v_ ? ref_out(a_, b_, ci_, s_, 1'b0) : 11'h0;
            m1[0] = v_ ? ref_out(a_, b_, ci_, s_, 1'b1) : 11'h0;
        end
        #1;
        chk("model", o0, m0[S]);
        chk("model_sat", o1, m1[S]);
    endtask

    initial begin
        for (int i = 0; i <= S; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end

        cyc(1, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("rst_c1", o0, 11'h000);
        cyc(1, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("rst_c2", o0, 11'h000);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("rst_rel", o0, 11'h000);

        cyc(0, 1, 1, 0, 8'h0F, 8'h01, 0);
        cyc(0, 1, 1, 0, 8'hFF, 8'h01, 0);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("add_carry", o0, {1'b1, 8'h10, 1'b0, 1'b0});
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("add_wrap", o0, {1'b1, 8'h00, 1'b1, 1'b0});

        cyc(0, 1, 1, 1, 8'h05, 8'h07, 0);
        cyc(0, 1, 1, 1, 8'h80, 8'h01, 0);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("sub_neg", o0, {1'b1, 8'hFE, 1'b0, 1'b0});
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("sub_ovf", o0, {1'b1, 8'h7F, 1'b1, 1'b1});
        chk("sat_neg", o1, {1'b1, 8'h80, 1'b1, 1'b1});

        cyc(0, 1, 1, 0, 8'h7F, 8'h01, 0);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("wrap_pos", o0, {1'b1, 8'h80, 1'b0, 1'b1});
        chk("sat_pos", o1, {1'b1, 8'h7F, 1'b0, 1'b1});

        nv = 0;
        cyc(0, 1, 1, 0, 8'h12, 8'h34, 0); nv += int'(ov0);
        cyc(0, 1, 1, 0, 8'hF0, 8'h20, 1); nv += int'(ov0);
        cyc(0, 1, 1, 1, 8'h10, 8'h20, 1); nv += int'(ov0);
        chk("stall_pre", o0, {1'b1, 8'h46, 1'b0, 1'b0});
        cyc(0, 0, 1, 0, 8'hAA, 8'h55, 0);
        cyc(0, 0, 1, 1, 8'h33, 8'h44, 1);
        cyc(0, 0, 0, 0, 8'h00, 8'h00, 0);
        chk("stall_hold", o0, {1'b1, 8'h46, 1'b0, 1'b0});
        cyc(0, 1, 1, 0, 8'h40, 8'h40, 0); nv += int'(ov0);
        chk("stall_t2", o0, {1'b1, 8'h11, 1'b1, 1'b0});
        cyc(0, 1, 1, 1, 8'h00, 8'h00, 0); nv += int'(ov0);
        chk("stall_t3", o0, {1'b1, 8'hEF, 1'b0, 1'b0});
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0); nv += int'(ov0);
        chk("stall_t4", o0, {1'b1, 8'h80, 1'b0, 1'b1});
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0); nv += int'(ov0);
        chk("stall_t5", o0, {1'b1, 8'h00, 1'b1, 1'b0});
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0); nv += int'(ov0);
        chk("emit_count", 11'(nv), 11'd5);

        cyc(0, 1, 1, 0, 8'h01, 8'h02, 0);
        cyc(0, 1, 1, 0, 8'h03, 8'h04, 0);
        cyc(1, 1, 1, 0, 8'h05, 8'h06, 0);
        chk("flush_0", o0, 11'h000);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("flush_1", o0, 11'h000);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("flush_2", o0, 11'h000);
        cyc(0, 1, 1, 0, 8'h21, 8'h01, 0);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("post_rst_early", o0, 11'h000);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);
        chk("post_rst_lat", o0, {1'b1, 8'h22, 1'b0, 1'b0});

        for (int i = 0; i < 200; i++) begin
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 4) != 0,
                $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 0, 0, 8'h00, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
